// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with a small prefetch queue.
// Issues sequential word fetches under a credit limit and buffers each
// {instruction, pc} pair for the core. A redirect flushes the queue and
// drops every response that was already in flight.
module ifu_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_occ;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [XLEN-1:0] r_q_data [DEPTH];
  logic [XLEN-1:0] r_q_pc   [DEPTH];

  logic            w_redir;
  logic [SW-1:0]   w_pending;
  logic            w_credit;
  logic            w_acc;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_eff_inflight;
  logic [XLEN-1:0] w_target;
  logic            w_unused_pc_lsb;

  // Handshake qualifiers and credit check
  assign w_redir        = redirect_valid & (r_state != S_IDLE);
  assign w_pending      = SW'(r_occ) + SW'(r_inflight);
  assign w_credit       = (w_pending < SW'(DEPTH));
  assign imem_req_valid = (r_state == S_FETCH) & w_credit & ~redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_acc          = imem_req_valid & imem_req_ready;
  assign w_drop         = imem_rsp_valid & ((r_discard != '0) | w_redir);
  assign w_push         = imem_rsp_valid & ~w_drop;
  assign w_pop          = instr_valid & instr_ready & ~w_redir;
  assign w_eff_inflight = r_inflight - CW'(imem_rsp_valid);
  assign w_target       = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  // Head of queue presented straight from the register array
  assign instr_valid = (r_occ != '0);
  assign instr       = instr_valid ? r_q_data[r_head] : '0;
  assign instr_pc    = instr_valid ? r_q_pc[r_head]   : '0;

  // Fetch control: state, PC tracking and in-flight / discard accounting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_acc) - CW'(imem_rsp_valid);

      if (w_redir) begin
        r_fetch_pc <= w_target;
      end else if (w_acc) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end

      if (w_redir) begin
        r_rsp_pc <= w_target;
      end else if (w_push) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end

      if (w_redir) begin
        r_discard <= w_eff_inflight;
      end else if (imem_rsp_valid && (r_discard != '0)) begin
        r_discard <= r_discard - CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_redir && (w_eff_inflight != '0)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_redir) begin
            r_state <= (w_eff_inflight != '0) ? S_DRAIN : S_FETCH;
          end else if (imem_rsp_valid && (r_discard == CW'(1))) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Prefetch queue: push kept responses at the tail, pop at the head, flush on redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (w_redir) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_q_data[r_tail] <= imem_rsp_data;
        r_q_pc[r_tail]   <= r_rsp_pc;
        r_tail           <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
    end
  end

  // Credit accounting must make a push into a full queue impossible
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(w_push && (r_occ == CW'(DEPTH))));
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: in-order memory model with random latency plus a
// queue-level reference of what the core should see.
module tb_ifu_prefetch;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  mreq_t       mq[$];
  ent_t        fq[$];
  int          total, bad, cyc;
  int          n_acc, n_pop, n_drop;
  logic [31:0] exp_req_addr;
  bit          started;
  int          lat_min, lat_max, p_ready, p_iready, p_redir;
  bit          force_redir, coinc_mode, coinc_hit;
  logic [31:0] force_rpc;
  int          redir_out, redir_drop_base;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One clock: compare at negedge, apply the edge to the model, drive next inputs
  task automatic step();
    logic        e_rv, acc_s, rsp_s, pop_s, redir_s, rst_s, stale_any;
    logic [31:0] tgt;
    mreq_t       m;
    ent_t        e;
    @(negedge clk);
    stale_any = 1'b0;
    for (int i = 0; i < mq.size(); i++) if (mq[i].stale) stale_any = 1'b1;
    e_rv = started && rst && !stale_any && (fq.size() + mq.size() < DEPTH) && !redirect_valid;
    chk("req_valid", imem_req_valid, e_rv);
    if (e_rv) chk("req_addr", imem_req_addr, exp_req_addr);
    chk("instr_valid", instr_valid, fq.size() != 0);
    if (fq.size() != 0) begin
      chk("instr_pc", instr_pc, fq[0].pc);
      chk("instr", instr, fq[0].data);
    end
    acc_s   = imem_req_valid && imem_req_ready;
    rsp_s   = imem_rsp_valid;
    pop_s   = instr_valid && instr_ready;
    redir_s = redirect_valid && started;
    tgt     = redirect_pc;
    rst_s   = rst;
    @(posedge clk);
    cyc++;
    if (!rst_s) begin
      mq.delete();
      fq.delete();
      exp_req_addr = RESET_PC;
      started = 1'b0;
    end else begin
      if (redir_s) begin
        fq.delete();
        if (rsp_s && mq.size() > 0) begin
          m = mq.pop_front();
          n_drop++;
        end
        for (int i = 0; i < mq.size(); i++) begin
          m = mq[i];
          m.stale = 1'b1;
          mq[i] = m;
        end
        exp_req_addr = {tgt[31:2], 2'b00};
      end else begin
        if (pop_s && fq.size() > 0) begin
          e = fq.pop_front();
          n_pop++;
        end
        if (rsp_s && mq.size() > 0) begin
          m = mq.pop_front();
          if (m.stale) begin
            n_drop++;
          end else begin
            e.pc   = m.addr;
            e.data = data_of(m.addr);
            fq.push_back(e);
          end
        end
      end
      if (acc_s) begin
        m.addr  = exp_req_addr;
        m.due   = cyc - 1 + int'($urandom_range(lat_max, lat_min));
        m.stale = 1'b0;
        mq.push_back(m);
        exp_req_addr = exp_req_addr + 32'd4;
        n_acc++;
      end
      started = 1'b1;
    end
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst && mq.size() > 0) begin
      if (mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data_of(mq[0].addr);
      end
    end
    imem_req_ready = (int'($urandom_range(99)) < p_ready);
    instr_ready    = (int'($urandom_range(99)) < p_iready);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom();
    if (started && rst) begin
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_rpc;
        force_redir    = 1'b0;
      end else if (coinc_mode && imem_rsp_valid && mq.size() == 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        coinc_mode     = 1'b0;
        coinc_hit      = 1'b1;
      end else if (int'($urandom_range(99)) < p_redir) begin
        redirect_valid = 1'b1;
      end
      if (redirect_valid) begin
        redir_out       = mq.size();
        redir_drop_base = n_drop;
      end
    end
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    #2;
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    mq.delete();
    fq.delete();
    exp_req_addr = RESET_PC;
    started = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int          base, base2;
    bit          found;
    logic [31:0] a0;
    total = 0; bad = 0; cyc = 0;
    n_acc = 0; n_pop = 0; n_drop = 0;
    exp_req_addr = RESET_PC; started = 1'b0;
    lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100; p_redir = 0;
    force_redir = 1'b0; coinc_mode = 1'b0; coinc_hit = 1'b0; force_rpc = '0;
    redir_out = 0; redir_drop_base = 0;
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset values
    #2;
    chk("init_req_valid", imem_req_valid, 1'b0);
    chk("init_instr_valid", instr_valid, 1'b0);
    chk("init_instr", instr, 32'h0);
    chk("init_instr_pc", instr_pc, 32'h0);
    chk("init_req_addr", imem_req_addr, RESET_PC);
    step();
    step();
    rst = 1'b1;

    // Streaming with 1-cycle memory: one instruction per cycle
    repeat (6) step();
    base = n_pop;
    repeat (20) step();
    chk("steady_pops", n_pop - base, 20);

    // Mid-stream reset, then back-pressure from the core
    p_iready = 0;
    async_reset();
    base = n_acc;
    repeat (12) step();
    chk("full_accepts", n_acc - base, DEPTH);
    chk("full_req_valid", imem_req_valid, 1'b0);
    p_iready = 100;
    step();
    p_iready = 0;
    base  = n_acc;
    base2 = n_pop;
    repeat (8) step();
    chk("one_pop", n_pop - base2, 1);
    chk("one_refill", n_acc - base, 1);

    // Memory stalls requests for 3 cycles
    p_iready = 100;
    repeat (5) step();
    p_ready = 0;
    step();
    base = n_acc;
    a0   = imem_req_addr;
    repeat (3) step();
    chk("stall_accepts", n_acc - base, 0);
    chk("stall_addr", imem_req_addr, a0);
    chk("stall_req_valid", imem_req_valid, 1'b1);
    p_ready = 100;

    // Redirect to 0x103 with 3-cycle memory latency
    lat_min = 3; lat_max = 3;
    repeat (15) step();
    force_rpc   = 32'h0000_0103;
    force_redir = 1'b1;
    step();
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    chk("redir_found", found, 1'b1);
    chk("redir_first_pc", instr_pc, 32'h0000_0100);
    chk("redir_first_instr", instr, data_of(32'h0000_0100));
    chk("redir_drops", n_drop - redir_drop_base, redir_out);

    // Redirect coincident with a response and two outstanding
    lat_min = 2; lat_max = 2;
    coinc_hit  = 1'b0;
    coinc_mode = 1'b1;
    for (int k = 0; k < 60 && !coinc_hit; k++) step();
    coinc_mode = 1'b0;
    chk("coinc_hit", coinc_hit, 1'b1);
    repeat (10) step();
    chk("coinc_drops", n_drop - redir_drop_base, 2);

    // Randomised traffic with redirects and one reset
    lat_min = 1; lat_max = 4; p_redir = 3;
    for (int i = 0; i < 1600; i++) begin
      if (i % 400 == 0) begin
        p_ready  = int'($urandom_range(100, 30));
        p_iready = int'($urandom_range(100, 20));
      end
      if (i == 800) async_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
